// File: rtl/segway_pkg.sv
// Shared types and default thresholds for the segway rider/steering logic.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } steer_state_t;

    localparam logic [11:0] DEF_MIN_RIDER_WT  = 12'h200;
    localparam logic [7:0]  DEF_WT_HYSTERESIS = 8'h40;

endpackage

// File: rtl/steer_en_tmr.sv
// Stability timer: 26-bit up-counter with a selectable terminal count.
module steer_en_tmr #(
    parameter bit fast_sim = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic full
);

    logic [25:0] tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= 26'd0;
        end else if (clr) begin
            tmr <= 26'd0;
        end else if (en) begin
            tmr <= tmr + 26'd1;
        end
    end

    assign full = fast_sim ? (&tmr[14:0]) : (&tmr);

endmodule

// File: rtl/steer_en.sv
// Rider presence/balance detection; enables steering after a stable period.
module steer_en
    import segway_pkg::*;
#(
    parameter bit          fast_sim      = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT  = DEF_MIN_RIDER_WT,
    parameter logic [7:0]  WT_HYSTERESIS = DEF_WT_HYSTERESIS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WT} + {5'd0, WT_HYSTERESIS};
    localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WT} - {5'd0, WT_HYSTERESIS};

    steer_state_t state, next_state;

    logic [12:0] sum;
    logic [12:0] diff;
    logic [11:0] diff_abs;
    logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
    logic        clr_tmr, tmr_full;

    assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff     = {1'b0, lft_ld} - {1'b0, rght_ld};
    assign diff_abs = diff[12] ? (~diff[11:0] + 12'd1) : diff[11:0];

    assign sum_gt_min    = sum > SUM_HI;
    assign sum_lt_min    = sum < SUM_LO;
    assign diff_gt_1_4   = {1'b0, diff_abs} > (sum >> 2);
    assign diff_gt_15_16 = {1'b0, diff_abs} > (sum - (sum >> 4));

    steer_en_tmr #(
        .fast_sim(fast_sim)
    ) u_tmr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_tmr),
        .en   (state == WAIT),
        .full (tmr_full)
    );

    always_comb begin
        next_state = state;
        clr_tmr    = 1'b0;
        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    next_state = WAIT;
                    clr_tmr    = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    next_state = IDLE;
                end else if (diff_gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    next_state = STEER_EN;
                end
            end
            STEER_EN: begin
                if (sum_lt_min) begin
                    next_state = IDLE;
                end else if (diff_gt_15_16) begin
                    next_state = WAIT;
                    clr_tmr    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state     <= next_state;
            en_steer  <= (next_state == STEER_EN);
            rider_off <= (next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_steer_en.sv
// Randomised scoreboard bench for steer_en with fast_sim=1.
module tb_steer_en;

    localparam int HOLD = 32768;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lft_ld, rght_ld;
    logic        en_steer, rider_off;

    typedef struct {
        int tgt;
        bit en;
        bit off;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   m_mode = 0;   // 0 no rider, 1 waiting for stability, 2 steering
    int   m_stable = 0; // consecutive balanced cycles spent waiting

    steer_en #(
        .fast_sim(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: rider present above 0x240, gone below 0x1C0, balanced while
    // |l-r| <= sum/4, steering after HOLD balanced cycles, lost when |l-r| > 15/16 sum.
    task automatic model_step(input int l, input int r);
        int s, d;
        exp_t e;
        s = l + r;
        d = (l > r) ? l - r : r - l;
        case (m_mode)
            0: if (s > 'h240) begin m_mode = 1; m_stable = 0; end
            1: begin
                if (s < 'h1C0) m_mode = 0;
                else if (d > s / 4) m_stable = 0;
                else if (m_stable == HOLD - 1) m_mode = 2;
                else m_stable++;
            end
            default: begin
                if (s < 'h1C0) m_mode = 0;
                else if (d > s - s / 16) begin m_mode = 1; m_stable = 0; end
            end
        endcase
        e.tgt = edge_cnt + 1;
        e.en  = (m_mode == 2);
        e.off = (m_mode == 0);
        q.push_back(e);
    endtask

    task automatic step(input int l, input int r);
        lft_ld  = 12'(l);
        rght_ld = 12'(r);
        model_step(l, r);
    endtask

    task automatic cycle(input int l, input int r);
        @(posedge clk);
        #1;
        step(l, r);
    endtask

    task automatic hold(input int l, input int r, input int n);
        for (int i = 0; i < n; i++) cycle(l, r);
    endtask

    task automatic wait_en(input int l, input int r, input string name);
        int n = 0;
        while (!en_steer && n < HOLD + 10) begin
            cycle(l, r);
            n++;
        end
        chk(name, n, (n >= HOLD + 1 && n <= HOLD + 3) ? n : HOLD + 2);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({name, "_en"}, en_steer, 1'b0);
        chk({name, "_off"}, rider_off, 1'b1);
        q.delete();
        m_mode   = 0;
        m_stable = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(int'(lft_ld), int'(rght_ld));
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && q.size() > 0 && q[0].tgt <= edge_cnt) begin
            e = q.pop_front();
            chk("en_steer", en_steer, e.en);
            chk("rider_off", rider_off, e.off);
            chk("exclusive", en_steer & rider_off, 1'b0);
        end
    end

    initial begin
        int l, r, run;
        rst_n   = 1'b0;
        lft_ld  = 12'h0;
        rght_ld = 12'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_en", en_steer, 1'b0);
        chk("reset_off", rider_off, 1'b1);
        rst_n = 1'b1;
        step(0, 0);
        hold(0, 0, 2000);

        // Rider steps on balanced, then steering after the stability period.
        cycle('h150, 'h150);
        wait_en('h150, 'h150, "first_enable_latency");

        // Heavy tilt drops back to waiting; milder tilt keeps timer clear.
        hold('h280, 'h010, 2);
        chk("tilt_en", en_steer, 1'b0);
        chk("tilt_off", rider_off, 1'b0);
        hold('h270, 'h010, 200);

        // Imbalanced wait restarts the full stability period.
        hold('h200, 'h0A0, 1000);
        chk("imbalance_en", en_steer, 1'b0);
        wait_en('h150, 'h150, "rebalance_latency");

        // Exactly at the low threshold: stay; just below: rider off.
        hold('h0E0, 'h0E0, 100);
        chk("low_edge_en", en_steer, 1'b1);
        hold('h0DF, 'h0DF, 3);
        chk("rider_left_off", rider_off, 1'b1);

        // Exactly at the high threshold: no pickup.
        hold('h120, 'h120, 20);
        chk("high_edge_off", rider_off, 1'b1);

        for (int k = 0; k < 150; k++) begin
            run = $urandom_range(1, 40);
            if ($urandom_range(0, 3) == 0) begin
                l = $urandom_range(0, 4095);
                r = $urandom_range(0, 4095);
            end else begin
                l = $urandom_range('h0B0, 'h160);
                r = $urandom_range('h0B0, 'h160);
            end
            hold(l, r, run);
        end

        // Reset while waiting returns outputs immediately.
        hold(0, 0, 3);
        hold('h150, 'h150, 5);
        chk("pre_reset_off", rider_off, 1'b0);
        do_reset("reset_mid_wait");
        hold(0, 0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
